// File: rtl/mul_sequencer_pkg.sv
// Shared execute-stage definitions: datapath word, ALU operation codes, multiply sequencer states.
// No logic; imported by the ALU, the multiply sequencer and their bench.
// Encodings are fixed 2-bit/4-bit codes so they match any decode elsewhere in the stage.
package mul_sequencer_pkg;

    localparam int WORD = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_EOR = 4'd4;
    localparam logic [3:0] ALU_MOV = 4'd5;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu.sv
// Shared execute-stage ALU: arithmetic and logic on two WIDTH-bit operands.
// Latency: combinational, no registers.
// Backpressure: none; the result follows the operands in the same cycle.
module alu
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = b;
        case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_EOR: result = a ^ b;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL (low WIDTH bits of a*b) by shift-and-add through the shared ALU; optional MUL_EARLY_EXIT_EN.
// Latency: WIDTH RUN cycles, or max(1, msb index of op_b + 1) with MUL_EARLY_EXIT_EN; then one DONE cycle.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic             alu_own,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e       state, state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             last_iter;
    logic [WIDTH-1:0] acc_nx;

`ifdef MUL_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain above the one consumed this cycle.
    assign last_iter = (count == CW'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
    assign last_iter = (count == CW'(WIDTH - 1));
`endif

    assign acc_nx = mplier[0] ? alu_result : acc;

    always_comb begin
        state_nx    = state;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        alu_own     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start) state_nx = MUL_RUN;
            end
            MUL_RUN: begin
                alu_a   = acc;
                alu_b   = mcand;
                alu_own = 1'b1;
                busy    = 1'b1;
                if (last_iter) state_nx = MUL_DONE;
            end
            MUL_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = MUL_IDLE;
            end
            default: state_nx = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MUL_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        count  <= '0;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    // Product is captured on the exit edge so it is valid while done is high.
                    if (last_iter) product <= acc_nx;
                end
                default: ;
            endcase
        end
    end

endmodule
